imem_boot_ctrl: RTL and testbench
=================================

Name: imem_boot_ctrl

Overview:
Sequencer and owner of the single-port instruction BSRAM (Gowin_SP, 2^ADDR_W x DATA_W). After reset it accepts a program image from a loader stream (UART/host) over a valid/ready handshake and writes it into BSRAM. It then releases the CPU and serves instruction fetches, compensating for the BSRAM's one-cycle read latency with a registered instruction and valid flag. It sits between the loader, the CPU fetch port and the BSRAM primitive, and replaces ad-hoc boot muxing at top level.

Parameters:
ADDR_W, 11, BSRAM address width (words = 2^ADDR_W)
DATA_W, 16, instruction / BSRAM data width

Ports:
clk  in  1  system clock; all logic on posedge
reset  in  1  synchronous, active-high reset
ld_valid  in  1  loader word valid
ld_ready  out  1  controller accepts loader word
ld_addr  in  ADDR_W  target word address
ld_data  in  DATA_W  instruction word
ld_last  in  1  final word of image (qualified by ld_valid)
reload  in  1  single-cycle request to re-enter load mode
cpu_addr  in  ADDR_W  CPU program counter
cpu_instr  out  DATA_W  fetched instruction (registered)
cpu_instr_valid  out  1  cpu_instr corresponds to a fetch issued in RUN
cpu_run  out  1  CPU may execute; 0 holds CPU
boot_done  out  1  image loaded at least once since reset (sticky)
load_count  out  ADDR_W+1  words accepted in current load, saturating at 2^ADDR_W
mem_ce, mem_wre, mem_oce  out  1 each  BSRAM controls
mem_ad  out  ADDR_W  BSRAM address
mem_din  out  DATA_W  BSRAM write data
mem_dout  in  DATA_W  BSRAM read data (valid one cycle after address sampled)

Behaviour:
- Reset values: ld_ready 0, cpu_instr 0, cpu_instr_valid 0, cpu_run 0, boot_done 0, load_count 0, mem_ce 0, mem_wre 0, mem_din 0, write-address register 0. mem_oce is constant 1. State after reset: LOAD (CLEAR when the optional feature is enabled).
- States: CLEAR, LOAD, DRAIN, RUN.
- LOAD:
  - ld_ready=1.
  - Accept on ld_valid&&ld_ready at edge A. Write registers (address, data, mem_wre=1, mem_ce=1) load at A. BSRAM writes at A+1.
  - Cycles with no accept: mem_wre=0, mem_ce=0.
  - load_count increments per accept and saturates.
  - Duplicate addresses: last write wins.
  - Accept with ld_last → DRAIN.
- DRAIN (one cycle):
  - ld_ready=0; completes the final write.
  - → RUN. boot_done←1 and cpu_run←1 at that edge.
- RUN:
  - mem_ad = cpu_addr (combinational mux); mem_ce=1, mem_wre=0.
  - cpu_instr←mem_dout every edge.
  - Valid shift pipe (2 stages) fed with 1.
  - cpu_instr_valid rises on the 2nd edge after entering RUN.
  - Steady latency: cpu_addr presented before edge E → cpu_instr valid after E+1.
- mem_ad outside RUN = write-address register.
- reload in RUN → LOAD at next edge:
  - cpu_run=0 and cpu_instr_valid=0 after that edge; cpu_instr←0 (NOP).
  - load_count←0.
  - boot_done stays 1.
- reload in LOAD/DRAIN/CLEAR is ignored.
- ld_valid outside LOAD is not accepted (ld_ready=0); no write is issued.
- Reset mid-operation (any state) aborts any in-flight write registration and restores reset values. A write launched at the same edge is dropped, because mem_wre is 0 after reset.

Optional Feature:
IMEM_CLEAR_EN:
- Defined: reset enters CLEAR. CLEAR writes 0 to addresses 0..2^ADDR_W-1, one per cycle (mem_ce=mem_wre=1, ld_ready=0), then moves to LOAD after the last address. A reload does not re-clear.
- Undefined: CLEAR is unreachable and reset goes directly to LOAD.

Decomposition:
- Package imem_pkg:
  - state_t enum {CLEAR, LOAD, DRAIN, RUN}
  - NOP_INSTR = 16'h0000
  - default ADDR_W/DATA_W constants
- Sub-module imem_fetch_pipe: instruction register plus 2-stage valid pipe, with flush input.

Test Plan:
- Reset, then load 0x00A1@0, 0x0078@1, 0x0091@2 (ld_last on the third word) → mem_wre pulses at the correct addresses; load_count=3; boot_done=cpu_run=1 two edges after the last accept.
- RUN with cpu_addr 0,1,2 on consecutive cycles → cpu_instr 00A1, 0078, 0091 back-to-back, each 2 edges after its address; cpu_instr_valid=1 continuously.
- Loader gaps (ld_valid low between words) → mem_wre=0 and mem_ce=0 in gap cycles; contents unchanged.
- reload in RUN → next cycle cpu_run=0, cpu_instr_valid=0, cpu_instr=0, ld_ready=1. Load 0x1234@1 with last, then fetch addr 1 → 0x1234; boot_done stays 1.
- Reset asserted after the first accepted word → all outputs at reset values, load_count=0. A ld_valid held during reset is not accepted.
- With IMEM_CLEAR_EN defined → ld_ready=0 for 2048 cycles after reset. Load 1 word @0 with last, then fetch addr 5 → 0x0000.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory boot controller.
package imem_pkg;

  localparam int unsigned ADDR_W_DEF = 11;
  localparam int unsigned DATA_W_DEF = 16;
  localparam logic [15:0] NOP_INSTR  = 16'h0000;

  typedef enum logic [1:0] {
    CLEAR,
    LOAD,
    DRAIN,
    RUN
  } state_t;

endpackage

// File: rtl/imem_fetch_pipe.sv
// Fetch-side instruction register and 2-stage valid pipe covering the BSRAM read latency.
module imem_fetch_pipe
  import imem_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              flush,
  input  logic [DATA_W-1:0] dout,
  output logic [DATA_W-1:0] instr,
  output logic              valid
);

  logic valid_s1;

  // Flush returns the CPU to a NOP with no valid fetch in flight.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      instr    <= DATA_W'(NOP_INSTR);
      valid_s1 <= 1'b0;
      valid    <= 1'b0;
    end else begin
      valid_s1 <= en;
      valid    <= valid_s1;
      if (en) begin
        instr <= dout;
      end
    end
  end

endmodule

// File: rtl/imem_boot_ctrl.sv
// Boot sequencer and owner of the instruction BSRAM: loads an image, then serves CPU fetches.
// Optional IMEM_CLEAR_EN: zero the whole BSRAM after reset before accepting the image.
module imem_boot_ctrl
  import imem_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  input  logic              reload,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [DATA_W-1:0] cpu_instr,
  output logic              cpu_instr_valid,
  output logic              cpu_run,
  output logic              boot_done,
  output logic [ADDR_W:0]   load_count,
  output logic              mem_ce,
  output logic              mem_wre,
  output logic              mem_oce,
  output logic [ADDR_W-1:0] mem_ad,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};
`ifdef IMEM_CLEAR_EN
  localparam state_t RESET_STATE = CLEAR;
`else
  localparam state_t RESET_STATE = LOAD;
`endif

  state_t            state;
  logic [ADDR_W-1:0] waddr;
  logic              accept;
`ifdef IMEM_CLEAR_EN
  logic [ADDR_W-1:0] clr_addr;
`endif

  assign accept  = (state == LOAD) && ld_valid && ld_ready;
  assign mem_oce = 1'b1;
  // The CPU owns the address port only while running.
  assign mem_ad  = (state == RUN) ? cpu_addr : waddr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RESET_STATE;
      ld_ready   <= 1'b0;
      cpu_run    <= 1'b0;
      boot_done  <= 1'b0;
      load_count <= '0;
      mem_ce     <= 1'b0;
      mem_wre    <= 1'b0;
      mem_din    <= '0;
      waddr      <= '0;
`ifdef IMEM_CLEAR_EN
      clr_addr   <= '0;
`endif
    end else begin
      case (state)
        CLEAR: begin
`ifdef IMEM_CLEAR_EN
          waddr    <= clr_addr;
          mem_din  <= '0;
          mem_ce   <= 1'b1;
          mem_wre  <= 1'b1;
          clr_addr <= clr_addr + 1'b1;
          if (clr_addr == '1) begin
            state    <= LOAD;
            ld_ready <= 1'b1;
          end
`else
          state    <= LOAD;
          ld_ready <= 1'b1;
`endif
        end
        LOAD: begin
          mem_ce   <= accept;
          mem_wre  <= accept;
          ld_ready <= !(accept && ld_last);
          if (accept) begin
            waddr   <= ld_addr;
            mem_din <= ld_data;
            if (load_count != CNT_MAX) begin
              load_count <= load_count + 1'b1;
            end
            if (ld_last) begin
              state <= DRAIN;
            end
          end
        end
        // Final write lands at this edge; the CPU port takes over afterwards.
        DRAIN: begin
          state     <= RUN;
          ld_ready  <= 1'b0;
          mem_ce    <= 1'b1;
          mem_wre   <= 1'b0;
          boot_done <= 1'b1;
          cpu_run   <= 1'b1;
        end
        RUN: begin
          if (reload) begin
            state      <= LOAD;
            ld_ready   <= 1'b1;
            cpu_run    <= 1'b0;
            load_count <= '0;
            mem_ce     <= 1'b0;
            mem_wre    <= 1'b0;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  imem_fetch_pipe #(
    .DATA_W(DATA_W)
  ) u_fetch_pipe (
    .clk  (clk),
    .reset(reset),
    .en   (state == RUN),
    .flush((state == RUN) && reload),
    .dout (mem_dout),
    .instr(cpu_instr),
    .valid(cpu_instr_valid)
  );

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Directed self-checking bench for imem_boot_ctrl with a behavioural single-port BSRAM.
module tb_imem_boot_ctrl;

  localparam int unsigned ADDR_W = 11;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned DEPTH  = 2 ** ADDR_W;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              ld_valid = 1'b0;
  logic              ld_ready;
  logic [ADDR_W-1:0] ld_addr = '0;
  logic [DATA_W-1:0] ld_data = '0;
  logic              ld_last = 1'b0;
  logic              reload = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [DATA_W-1:0] cpu_instr;
  logic              cpu_instr_valid;
  logic              cpu_run;
  logic              boot_done;
  logic [ADDR_W:0]   load_count;
  logic              mem_ce, mem_wre, mem_oce;
  logic [ADDR_W-1:0] mem_ad;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout = '0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  imem_boot_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_addr(ld_addr), .ld_data(ld_data), .ld_last(ld_last), .reload(reload),
    .cpu_addr(cpu_addr), .cpu_instr(cpu_instr), .cpu_instr_valid(cpu_instr_valid),
    .cpu_run(cpu_run), .boot_done(boot_done), .load_count(load_count),
    .mem_ce(mem_ce), .mem_wre(mem_wre), .mem_oce(mem_oce), .mem_ad(mem_ad),
    .mem_din(mem_din), .mem_dout(mem_dout)
  );

  // BSRAM model: registered read, preloaded with a marker pattern on the first edge.
  logic [DATA_W-1:0] bram [0:DEPTH-1];
  logic              bram_init = 1'b0;
  always @(posedge clk) begin
    if (!bram_init) begin
      for (int i = 0; i < DEPTH; i++) bram[i] <= 16'hDEAD;
      bram_init <= 1'b1;
    end else if (mem_ce) begin
      if (mem_wre) bram[mem_ad] <= mem_din;
      else         mem_dout <= bram[mem_ad];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; ld_valid = 1'b1; ld_addr = 11'd7; ld_data = 16'hCAFE; ld_last = 1'b1;
    tick(); tick();
    total++; if (ld_ready !== 1'b0) begin bad++; $display("FAIL reset_ld_ready got=%0h want=0", ld_ready); end
    total++; if (cpu_instr !== 16'h0000) begin bad++; $display("FAIL reset_cpu_instr got=%0h want=0", cpu_instr); end
    total++; if (cpu_instr_valid !== 1'b0) begin bad++; $display("FAIL reset_instr_valid got=%0h want=0", cpu_instr_valid); end
    total++; if (cpu_run !== 1'b0) begin bad++; $display("FAIL reset_cpu_run got=%0h want=0", cpu_run); end
    total++; if (boot_done !== 1'b0) begin bad++; $display("FAIL reset_boot_done got=%0h want=0", boot_done); end
    total++; if (load_count !== 12'd0) begin bad++; $display("FAIL reset_load_count got=%0d want=0", load_count); end
    total++; if (mem_ce !== 1'b0 || mem_wre !== 1'b0) begin bad++; $display("FAIL reset_mem_ctl got ce=%0h wre=%0h want 0 0", mem_ce, mem_wre); end
    total++; if (mem_oce !== 1'b1) begin bad++; $display("FAIL reset_mem_oce got=%0h want=1", mem_oce); end
    total++; if (mem_din !== 16'h0000 || mem_ad !== 11'd0) begin bad++; $display("FAIL reset_mem_bus got din=%0h ad=%0h want 0 0", mem_din, mem_ad); end
    // ld_valid still held across the first edge after release: ld_ready is 0 so nothing is taken
    reset = 1'b0;
    tick();
    total++; if (load_count !== 12'd0) begin bad++; $display("FAIL reset_release_no_accept got=%0d want=0", load_count); end
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  task automatic test_load();
    int n;
    n = 0;
    while (!ld_ready && n < 4000) begin tick(); n++; end
    total++; if (ld_ready !== 1'b1) begin bad++; $display("FAIL load_wait_ready got=%0h want=1 after %0d cycles", ld_ready, n); end
    ld_valid = 1'b1; ld_addr = 11'd0; ld_data = 16'h00A1; ld_last = 1'b0;
    tick();
    total++; if (mem_wre !== 1'b1 || mem_ce !== 1'b1 || mem_ad !== 11'd0 || mem_din !== 16'h00A1)
      begin bad++; $display("FAIL load_w0 got wre=%0h ce=%0h ad=%0h din=%0h want 1 1 0 00a1", mem_wre, mem_ce, mem_ad, mem_din); end
    ld_addr = 11'd1; ld_data = 16'h0078;
    tick();
    total++; if (mem_wre !== 1'b1 || mem_ad !== 11'd1 || mem_din !== 16'h0078 || load_count !== 12'd2)
      begin bad++; $display("FAIL load_w1 got wre=%0h ad=%0h din=%0h cnt=%0d want 1 1 0078 2", mem_wre, mem_ad, mem_din, load_count); end
    ld_addr = 11'd2; ld_data = 16'h0091; ld_last = 1'b1;
    tick();
    ld_valid = 1'b0; ld_last = 1'b0;
    total++; if (mem_wre !== 1'b1 || mem_ad !== 11'd2 || load_count !== 12'd3 || ld_ready !== 1'b0 || boot_done !== 1'b0)
      begin bad++; $display("FAIL load_w2 got wre=%0h ad=%0h cnt=%0d rdy=%0h done=%0h want 1 2 3 0 0", mem_wre, mem_ad, load_count, ld_ready, boot_done); end
    tick();
    total++; if (boot_done !== 1'b1 || cpu_run !== 1'b1 || mem_wre !== 1'b0 || cpu_instr_valid !== 1'b0)
      begin bad++; $display("FAIL load_to_run got done=%0h run=%0h wre=%0h vld=%0h want 1 1 0 0", boot_done, cpu_run, mem_wre, cpu_instr_valid); end
  endtask

  task automatic test_fetch();
    cpu_addr = 11'd0;
    tick();
    total++; if (cpu_instr_valid !== 1'b0) begin bad++; $display("FAIL fetch_first_edge_valid got=%0h want=0", cpu_instr_valid); end
    cpu_addr = 11'd1;
    tick();
    total++; if (cpu_instr_valid !== 1'b1 || cpu_instr !== 16'h00A1) begin bad++; $display("FAIL fetch_a0 got vld=%0h instr=%0h want 1 00a1", cpu_instr_valid, cpu_instr); end
    cpu_addr = 11'd2;
    tick();
    total++; if (cpu_instr_valid !== 1'b1 || cpu_instr !== 16'h0078) begin bad++; $display("FAIL fetch_a1 got vld=%0h instr=%0h want 1 0078", cpu_instr_valid, cpu_instr); end
    ld_valid = 1'b1; ld_addr = 11'd0; ld_data = 16'hFFFF; ld_last = 1'b1;
    tick();
    total++; if (cpu_instr_valid !== 1'b1 || cpu_instr !== 16'h0091) begin bad++; $display("FAIL fetch_a2 got vld=%0h instr=%0h want 1 0091", cpu_instr_valid, cpu_instr); end
    total++; if (ld_ready !== 1'b0 || mem_wre !== 1'b0 || load_count !== 12'd3)
      begin bad++; $display("FAIL run_ignores_loader got rdy=%0h wre=%0h cnt=%0d want 0 0 3", ld_ready, mem_wre, load_count); end
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  task automatic test_reload_gaps();
    reload = 1'b1;
    tick();
    reload = 1'b0;
    total++; if (cpu_run !== 1'b0 || cpu_instr_valid !== 1'b0 || cpu_instr !== 16'h0000 || ld_ready !== 1'b1)
      begin bad++; $display("FAIL reload_exit got run=%0h vld=%0h instr=%0h rdy=%0h want 0 0 0 1", cpu_run, cpu_instr_valid, cpu_instr, ld_ready); end
    total++; if (load_count !== 12'd0 || boot_done !== 1'b1) begin bad++; $display("FAIL reload_state got cnt=%0d done=%0h want 0 1", load_count, boot_done); end
    ld_valid = 1'b1; ld_addr = 11'd1; ld_data = 16'hBEEF;
    tick();
    ld_valid = 1'b0;
    total++; if (mem_wre !== 1'b1 || mem_ad !== 11'd1 || mem_din !== 16'hBEEF)
      begin bad++; $display("FAIL gap_w0 got wre=%0h ad=%0h din=%0h want 1 1 beef", mem_wre, mem_ad, mem_din); end
    reload = 1'b1;
    tick();
    reload = 1'b0;
    total++; if (mem_wre !== 1'b0 || mem_ce !== 1'b0 || ld_ready !== 1'b1 || load_count !== 12'd1)
      begin bad++; $display("FAIL gap_cycle1 got wre=%0h ce=%0h rdy=%0h cnt=%0d want 0 0 1 1", mem_wre, mem_ce, ld_ready, load_count); end
    tick();
    total++; if (mem_wre !== 1'b0 || mem_ce !== 1'b0) begin bad++; $display("FAIL gap_cycle2 got wre=%0h ce=%0h want 0 0", mem_wre, mem_ce); end
    ld_valid = 1'b1; ld_addr = 11'd1; ld_data = 16'h1234; ld_last = 1'b1;
    tick();
    ld_valid = 1'b0; ld_last = 1'b0;
    total++; if (load_count !== 12'd2 || ld_ready !== 1'b0 || mem_din !== 16'h1234)
      begin bad++; $display("FAIL gap_last got cnt=%0d rdy=%0h din=%0h want 2 0 1234", load_count, ld_ready, mem_din); end
    tick();
    cpu_addr = 11'd1;
    tick();
    cpu_addr = 11'd0;
    tick();
    total++; if (cpu_instr_valid !== 1'b1 || cpu_instr !== 16'h1234) begin bad++; $display("FAIL reload_fetch_a1 got vld=%0h instr=%0h want 1 1234", cpu_instr_valid, cpu_instr); end
    cpu_addr = 11'd2;
    tick();
    total++; if (cpu_instr !== 16'h00A1) begin bad++; $display("FAIL reload_fetch_a0 got=%0h want=00a1", cpu_instr); end
    tick();
    total++; if (cpu_instr !== 16'h0091 || boot_done !== 1'b1) begin bad++; $display("FAIL reload_fetch_a2 got instr=%0h done=%0h want 0091 1", cpu_instr, boot_done); end
  endtask

  task automatic test_reset_mid();
    reload = 1'b1;
    tick();
    reload = 1'b0;
    ld_valid = 1'b1; ld_addr = 11'd4; ld_data = 16'hAAAA;
    tick();
    total++; if (mem_wre !== 1'b1 || load_count !== 12'd1) begin bad++; $display("FAIL mid_accept got wre=%0h cnt=%0d want 1 1", mem_wre, load_count); end
    reset = 1'b1; ld_addr = 11'd5; ld_data = 16'hBBBB;
    tick();
    total++; if (mem_wre !== 1'b0 || mem_ce !== 1'b0 || load_count !== 12'd0 || ld_ready !== 1'b0)
      begin bad++; $display("FAIL mid_reset_ctl got wre=%0h ce=%0h cnt=%0d rdy=%0h want 0 0 0 0", mem_wre, mem_ce, load_count, ld_ready); end
    total++; if (boot_done !== 1'b0 || cpu_run !== 1'b0 || mem_din !== 16'h0000 || mem_ad !== 11'd0)
      begin bad++; $display("FAIL mid_reset_out got done=%0h run=%0h din=%0h ad=%0h want 0 0 0 0", boot_done, cpu_run, mem_din, mem_ad); end
    tick();
    reset = 1'b0; ld_valid = 1'b0;
    tick();
    total++; if (bram[5] !== 16'hDEAD) begin bad++; $display("FAIL mid_dropped_write got=%0h want=dead", bram[5]); end
  endtask

  task automatic test_saturate();
    int n;
    n = 0;
    while (!ld_ready && n < 4000) begin tick(); n++; end
    total++; if (ld_ready !== 1'b1) begin bad++; $display("FAIL sat_wait_ready got=%0h want=1", ld_ready); end
    ld_valid = 1'b1; ld_last = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      ld_addr = ADDR_W'(i); ld_data = DATA_W'(i);
      tick();
    end
    total++; if (load_count !== 12'h800) begin bad++; $display("FAIL sat_full got=%0h want=800", load_count); end
    tick();
    total++; if (load_count !== 12'h800 || ld_ready !== 1'b1) begin bad++; $display("FAIL sat_hold got cnt=%0h rdy=%0h want 800 1", load_count, ld_ready); end
    ld_valid = 1'b0;
  endtask

`ifdef IMEM_CLEAR_EN
  task automatic test_clear();
    int n;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n = 0;
    while (!ld_ready && n < 4000) begin tick(); n++; end
    total++; if (n != 2048) begin bad++; $display("FAIL clear_cycles got=%0d want=2048", n); end
    ld_valid = 1'b1; ld_addr = 11'd0; ld_data = 16'h7777; ld_last = 1'b1;
    tick();
    ld_valid = 1'b0; ld_last = 1'b0;
    tick();
    cpu_addr = 11'd5;
    tick(); tick();
    total++; if (cpu_instr_valid !== 1'b1 || cpu_instr !== 16'h0000) begin bad++; $display("FAIL clear_fetch_a5 got vld=%0h instr=%0h want 1 0", cpu_instr_valid, cpu_instr); end
  endtask
`endif

  initial begin
    test_reset();
    test_load();
    test_fetch();
    test_reload_gaps();
    test_reset_mid();
    test_saturate();
`ifdef IMEM_CLEAR_EN
    test_clear();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
